fetch_pc_unit: RTL
==================

// Module: fetch_pc_unit
// PURPOSE
// - Fetch-side next-PC generator that drives the branch predictor's incoming_instruction_pc.
// - Consumes predictions one cycle later. Carries each prediction with its instruction slot
//   through decode to execute, and resolves it there against the actual branch outcome.
// - On a mispredict: redirects fetch, flushes younger slots, counts branches and mispredicts.
// PARAMETERS
// - RESET_VECTOR  32'h0000_0000  first fetch PC after reset
// - CNT_WIDTH     32             width of both performance counters
// PORTS
// - clock               in   1          single clock, posedge
// - reset_n             in   1          asynchronous, active-low reset
// - enable              in   1          pipeline advance; same signal the predictor uses
// - fetch_pc            out  XLEN       F1 PC; drives predictor and instruction memory
// - pred_taken          in   1          predictor output for the PC issued last enabled cycle (F2)
// - pred_target         in   XLEN       predicted target for the F2 slot
// - ex_branch_active    in   1          instruction in EX is a branch or jump
// - ex_branch_taken     in   1          actual direction
// - ex_branch_target    in   XLEN       actual target when taken
// - f2_valid/d_valid/ex_valid  out 1    slot-valid bits per stage
// - ex_pc               out  XLEN       PC of the EX slot
// - flush               out  1          combinational; kills F1/F2/D in the downstream stages this cycle
// - branch_count        out  CNT_WIDTH  resolved branches in EX
// - mispredict_count    out  CNT_WIDTH  resolved mispredicts
// BEHAVIOUR
// - Reset (async, immediate, also mid-operation):
//   - fetch_pc=RESET_VECTOR; all valids, pc/pred regs, flush and counters = 0.
// - Slots: F1 -> F2 -> D -> EX.
//   - Each slot holds {valid, pc, pred_taken, pred_target}.
//   - pred fields are captured from the inputs when the slot moves F2 -> D.
//   - First slot leaves F1 on the first enabled edge after release, so ex_valid first rises 3 enabled edges later.
// - enable=0: all state holds, flush=0, counters hold.
// - mispredict (comb) = ex_valid & (
//     ex_branch_active & (taken != pred_taken | (taken & target != pred_target))
//     | !ex_branch_active & pred_taken ).
// - Next-PC priority, applied on the enabled edge:
//   1. mispredict: fetch_pc <= taken ? ex_branch_target : ex_pc+4.
//      Clear F2/D/EX valids; F1 (new pc) valid; flush=1.
//   2. f2_valid & pred_taken: fetch_pc <= pred_target.
//      Kill the slot currently in F1 (F2 valid <= 0); 1-bubble taken penalty.
//   3. else: fetch_pc <= fetch_pc+4.
// - Simultaneous mispredict and F2 prediction: mispredict wins; the prediction is discarded.
// - Arithmetic: +4 modulo 2^XLEN (0xFFFF_FFFC+4 = 0x0).
//   - Targets are used unmodified; sim assertion that targets have bits[1:0]==0.
// - Counters: +1 on enabled edge with ex_valid&ex_branch_active (branch) / mispredict; wrap at 2^CNT_WIDTH.
// - EX slot is consumed every enabled edge; ex_* is valid the cycle ex_valid=1.
// STRUCTURE
// - Shared pkg: XLEN, fetch_slot_t {valid, pc, pred_taken, pred_target}, next_pc_sel_e {SEL_SEQ, SEL_PRED, SEL_REDIRECT}.
// - Sub-module fetch_slot_reg: one enable/kill/async-reset slot register, instantiated for F2, D, EX.
// - Top: next-PC mux, mispredict compare, counters.
// TESTING
// - Reset release, no branches:
//   -> fetch_pc 0x0,0x4,0x8,...; ex_valid rises after 3 edges with ex_pc=0x0.
// - pred_taken=1, target 0x100 while F2 pc=0x8:
//   -> next fetch_pc=0x100; slot 0xC never shows ex_valid.
// - EX pc 0x20 pred not-taken, actual taken to 0x80:
//   -> flush=1, fetch_pc=0x80 next, mispredict_count 0->1, branch_count 0->1.
// - Pred taken 0x100, actual taken 0x104:
//   -> mispredict, redirect 0x104.
//   - Same-cycle F2 pred_taken to 0x200: ignored.
// - enable=0 for 3 cycles mid-stream:
//   -> fetch_pc, valids, counters frozen; flush=0 even with a mismatching EX slot.
// - RESET_VECTOR=0xFFFF_FFFC:
//   -> fetch_pc wraps to 0x0.
//   - reset_n pulsed mid-run -> immediate return to reset values.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit_pkg
// Shared types for the fetch-side next-PC generator.
//   XLEN           : architectural address width
//   fetch_slot_t   : per-stage slot {valid, pc, pred_taken, pred_target}
//   next_pc_sel_e  : which source feeds the next fetch PC
//   pc_plus4       : sequential successor, wraps modulo 2^XLEN
// -----------------------------------------------------------------------------
package fetch_pc_unit_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } fetch_slot_t;

  typedef enum logic [1:0] {
    SEL_SEQ      = 2'd0,
    SEL_PRED     = 2'd1,
    SEL_REDIRECT = 2'd2
  } next_pc_sel_e;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_slot_reg.sv
// -----------------------------------------------------------------------------
// fetch_slot_reg
// One pipeline slot register (used for F2, D and EX).
//   clock    : clock, posedge
//   reset_n  : asynchronous active-low reset, clears the whole slot
//   i_en     : pipeline advance; the slot holds when low
//   i_kill   : the incoming slot is captured as a bubble (valid forced low)
//   i_slot   : slot contents from the previous stage
//   o_slot   : registered slot contents
// -----------------------------------------------------------------------------
import fetch_pc_unit_pkg::*;

module fetch_slot_reg (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_en,
  input  logic        i_kill,
  input  fetch_slot_t i_slot,
  output fetch_slot_t o_slot
);

  fetch_slot_t r_slot;
  fetch_slot_t w_slot_next;

  always_comb begin
    w_slot_next       = i_slot;
    w_slot_next.valid = i_slot.valid & ~i_kill;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_slot <= '0;
    end else if (i_en) begin
      r_slot <= w_slot_next;
    end
  end

  assign o_slot = r_slot;

endmodule

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
// Fetch-side next-PC generator. Issues fetch_pc (F1) to the branch predictor
// and instruction memory, consumes the prediction for the F2 slot one cycle
// later, carries it through D to EX and resolves it there.
//   clock, reset_n            : clock (posedge) / async active-low reset
//   enable                    : pipeline advance, shared with the predictor
//   fetch_pc                  : F1 PC
//   pred_taken, pred_target   : prediction for the F2 slot
//   ex_branch_active/taken/target : actual outcome of the EX instruction
//   f2_valid, d_valid, ex_valid, ex_pc : slot status
//   flush                     : kill F1/F2/D downstream this cycle
//   branch_count, mispredict_count : wrapping performance counters
// -----------------------------------------------------------------------------
import fetch_pc_unit_pkg::*;

module fetch_pc_unit #(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int              CNT_WIDTH    = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  output logic [XLEN-1:0]      fetch_pc,
  input  logic                 pred_taken,
  input  logic [XLEN-1:0]      pred_target,
  input  logic                 ex_branch_active,
  input  logic                 ex_branch_taken,
  input  logic [XLEN-1:0]      ex_branch_target,
  output logic                 f2_valid,
  output logic                 d_valid,
  output logic                 ex_valid,
  output logic [XLEN-1:0]      ex_pc,
  output logic                 flush,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  logic [XLEN-1:0]      r_fetch_pc;
  logic [CNT_WIDTH-1:0] r_branch_count;
  logic [CNT_WIDTH-1:0] r_mispredict_count;

  fetch_slot_t  w_f2_in;
  fetch_slot_t  w_f2_slot;
  fetch_slot_t  w_d_in;
  fetch_slot_t  w_d_slot;
  fetch_slot_t  w_ex_slot;

  logic         w_dir_wrong;
  logic         w_tgt_wrong;
  logic         w_mispredict;
  logic         w_pred_redirect;
  logic         w_kill_f1;
  next_pc_sel_e w_next_sel;
  logic [XLEN-1:0] w_redirect_pc;
  logic [XLEN-1:0] w_next_pc;

  // The PC in F1 is always a live fetch; it only becomes a bubble when it is
  // overtaken by a redirect (mispredict or taken prediction in F2).
  always_comb begin
    w_f2_in       = '0;
    w_f2_in.valid = 1'b1;
    w_f2_in.pc    = r_fetch_pc;
  end

  // The predictor answers for the F2 slot, so its output is latched as the
  // slot moves into D.
  always_comb begin
    w_d_in             = w_f2_slot;
    w_d_in.pred_taken  = pred_taken;
    w_d_in.pred_target = pred_target;
  end

  fetch_slot_reg u_f2_slot (
    .clock   (clock),
    .reset_n (reset_n),
    .i_en    (enable),
    .i_kill  (w_kill_f1),
    .i_slot  (w_f2_in),
    .o_slot  (w_f2_slot)
  );

  fetch_slot_reg u_d_slot (
    .clock   (clock),
    .reset_n (reset_n),
    .i_en    (enable),
    .i_kill  (w_mispredict),
    .i_slot  (w_d_in),
    .o_slot  (w_d_slot)
  );

  fetch_slot_reg u_ex_slot (
    .clock   (clock),
    .reset_n (reset_n),
    .i_en    (enable),
    .i_kill  (w_mispredict),
    .i_slot  (w_d_slot),
    .o_slot  (w_ex_slot)
  );

  // A non-branch that was predicted taken also mispredicts: fetch went to a
  // bogus target and must resume at ex_pc+4.
  always_comb begin
    w_dir_wrong     = ex_branch_taken != w_ex_slot.pred_taken;
    w_tgt_wrong     = ex_branch_taken & (ex_branch_target != w_ex_slot.pred_target);
    w_mispredict    = w_ex_slot.valid &
                      ((ex_branch_active & (w_dir_wrong | w_tgt_wrong)) |
                       (~ex_branch_active & w_ex_slot.pred_taken));
    w_pred_redirect = w_f2_slot.valid & pred_taken;
    w_kill_f1       = w_mispredict | w_pred_redirect;
  end

  // Mispredict outranks the F2 prediction: the F2 slot is younger and dies.
  always_comb begin
    w_next_sel    = SEL_SEQ;
    w_redirect_pc = ex_branch_taken ? ex_branch_target : pc_plus4(w_ex_slot.pc);
    w_next_pc     = pc_plus4(r_fetch_pc);
    if (w_mispredict) begin
      w_next_sel = SEL_REDIRECT;
    end else if (w_pred_redirect) begin
      w_next_sel = SEL_PRED;
    end
    case (w_next_sel)
      SEL_REDIRECT: w_next_pc = w_redirect_pc;
      SEL_PRED:     w_next_pc = pred_target;
      default:      w_next_pc = pc_plus4(r_fetch_pc);
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc <= RESET_VECTOR;
    end else if (enable) begin
      r_fetch_pc <= w_next_pc;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (enable) begin
      if (w_ex_slot.valid & ex_branch_active) begin
        r_branch_count <= r_branch_count + CNT_WIDTH'(1);
      end
      if (w_mispredict) begin
        r_mispredict_count <= r_mispredict_count + CNT_WIDTH'(1);
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (reset_n && enable && w_pred_redirect) begin
      assert (pred_target[1:0] == 2'b00)
        else $error("pred_target %h not word aligned", pred_target);
    end
    if (reset_n && enable && w_ex_slot.valid && ex_branch_active && ex_branch_taken) begin
      assert (ex_branch_target[1:0] == 2'b00)
        else $error("ex_branch_target %h not word aligned", ex_branch_target);
    end
  end
`endif

  assign fetch_pc         = r_fetch_pc;
  assign f2_valid         = w_f2_slot.valid;
  assign d_valid          = w_d_slot.valid;
  assign ex_valid         = w_ex_slot.valid;
  assign ex_pc            = w_ex_slot.pc;
  assign flush            = w_mispredict & enable;
  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule
